// File: rtl/ring_buf_pkg.sv
// Sizing and pointer helpers shared by the RAM ring-buffer controller.
package ring_buf_pkg;

  // Number of RAM entries addressed by addr_w bits.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Fill-level width: holds 0..DEPTH+1 (RAM entries plus the head register).
  function automatic int unsigned lvl_w_of(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  // Circular pointer increment, wrapping from depth-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_ring_buffer_ctrl.sv
// Sequences an external dual-port RAM as a single-clock circular buffer with
// first-word-fall-through output; the head sample is the RAM's registered read data.
module ram_ring_buffer_ctrl
  import ring_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned AFULL_TH   = 3072
) (
  input  logic                        clock___i,
  input  logic                        rst_n___i,
  input  logic                        flush__i,
  input  logic [DATA_WIDTH-1:0]       in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ADDR_WIDTH:0]         level_o,
  output logic                        almost_full_o,
  output logic                        overflow_o,
  output logic                        ram_we_o,
  output logic [ADDR_WIDTH-1:0]       ram_waddr_o,
  output logic [DATA_WIDTH-1:0]       ram_wdata_o,
  output logic                        ram_re_o,
  output logic [ADDR_WIDTH-1:0]       ram_raddr_o,
  input  logic [DATA_WIDTH-1:0]       ram_rdata_i
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned LVL_W = lvl_w_of(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]      mem_cnt;
  logic                  out_valid;
  logic                  overflow;

  logic                  not_full;
  logic                  not_empty;
  logic                  head_free;
  logic                  wr;
  logic                  rd;

  // Handshake decode; reset and flush both block any RAM access this cycle.
  assign not_full   = (mem_cnt != LVL_W'(DEPTH));
  assign not_empty  = (mem_cnt != LVL_W'(0));
  assign head_free  = ~out_valid | out_ready_i;
  assign in_ready_o = rst_n___i & not_full & ~flush__i;
  assign wr         = in_valid_i & in_ready_o;
  assign rd         = rst_n___i & head_free & not_empty & ~flush__i;

  assign ram_we_o    = wr;
  assign ram_waddr_o = wr_ptr;
  assign ram_wdata_o = in_data_i;
  assign ram_re_o    = rd;
  assign ram_raddr_o = rd_ptr;

  assign out_data_o    = ram_rdata_i;
  assign out_valid_o   = out_valid;
  assign overflow_o    = overflow;
  assign level_o       = mem_cnt + LVL_W'(out_valid);
  assign almost_full_o = (32'(level_o) >= AFULL_TH);

  // Pointers, RAM occupancy, head-valid and sticky overflow; flush acts like reset.
  always_ff @(posedge clock___i) begin
    if (!rst_n___i || flush__i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= ADDR_WIDTH'(wrap_inc(32'(wr_ptr), DEPTH));
      if (rd) rd_ptr <= ADDR_WIDTH'(wrap_inc(32'(rd_ptr), DEPTH));
      mem_cnt <= mem_cnt + LVL_W'(wr) - LVL_W'(rd);
      if (head_free) out_valid <= rd;
      if (in_valid_i && !in_ready_o) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_ring_buffer_ctrl.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// ring buffer, with a behavioural 1-cycle-latency RAM beside the controller.
module tb_ram_ring_buffer_ctrl;

  localparam int unsigned DW    = 12;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
  localparam int unsigned AF    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_ring_buffer_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_TH  (AF)
  ) dut (
    .clock___i    (clk),
    .rst_n___i    (rst_n),
    .flush__i     (flush),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .level_o      (level),
    .almost_full_o(almost_full),
    .overflow_o   (overflow),
    .ram_we_o     (ram_we),
    .ram_waddr_o  (ram_waddr),
    .ram_wdata_o  (ram_wdata),
    .ram_re_o     (ram_re),
    .ram_raddr_o  (ram_raddr),
    .ram_rdata_i  (ram_rdata)
  );

  // Behavioural dual-port RAM: registered read, holds rdata while re is low.
  logic [DW-1:0] ram_mem [DEPTH];
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_raddr];
  end

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 12'habc;
    out_ready = 1'b1;
    next();
    #4;
    checks++;
    if ({in_ready, ram_we, ram_re, out_valid, overflow, almost_full, level} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {in_ready, ram_we, ram_re, out_valid, overflow, almost_full, level}, 9'b0);
    end
    idle();
    rst_n = 1'b1;
    next();
  endtask

  // Push one sample into an empty buffer; head appears two cycles later.
  task automatic test_single_push();
    in_valid = 1'b1; in_data = 12'h001; out_ready = 1'b1;
    #4;
    checks++;
    if ({ram_we, ram_waddr, ram_wdata, out_valid} !== {1'b1, 2'd0, 12'h001, 1'b0}) begin
      errors++;
      $display("FAIL single_write: got %h want %h",
               {ram_we, ram_waddr, ram_wdata, out_valid}, {1'b1, 2'd0, 12'h001, 1'b0});
    end
    next();
    in_valid = 1'b0;
    #4;
    checks++;
    if ({out_valid, ram_re, ram_raddr, level} !== {1'b0, 1'b1, 2'd0, 3'd1}) begin
      errors++;
      $display("FAIL single_read_issue: got %b want %b",
               {out_valid, ram_re, ram_raddr, level}, {1'b0, 1'b1, 2'd0, 3'd1});
    end
    next();
    #4;
    checks++;
    if ({out_valid, out_data, level} !== {1'b1, 12'h001, 3'd1}) begin
      errors++;
      $display("FAIL single_head: got %h want %h",
               {out_valid, out_data, level}, {1'b1, 12'h001, 3'd1});
    end
    next();
    #4;
    checks++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL single_drained: got %b want %b", {out_valid, level}, {1'b0, 3'd0});
    end
    out_ready = 1'b0;
    next();
  endtask

  // Back-to-back pushes with the consumer stalled: five fit (four RAM + head).
  task automatic test_fill_overflow();
    int exp_lvl;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(12'h010 + k);
      out_ready = 1'b0;
      #4;
      exp_lvl = (k < 5) ? k : 5;
      checks++;
      if ({in_ready, overflow, almost_full, level} !==
          {(k < 5), 1'b0, (exp_lvl >= int'(AF)), LW'(exp_lvl)}) begin
        errors++;
        $display("FAIL fill_step%0d: got %b want %b", k,
                 {in_ready, overflow, almost_full, level},
                 {(k < 5), 1'b0, (exp_lvl >= int'(AF)), LW'(exp_lvl)});
      end
      next();
    end
    in_valid = 1'b0;
    #4;
    checks++;
    if ({overflow, almost_full, level, out_valid, out_data} !==
        {1'b1, 1'b1, 3'd5, 1'b1, 12'h010}) begin
      errors++;
      $display("FAIL fill_final: got %h want %h",
               {overflow, almost_full, level, out_valid, out_data},
               {1'b1, 1'b1, 3'd5, 1'b1, 12'h010});
    end
  endtask

  // Drain to three samples, then flush alongside a push attempt.
  task automatic test_flush();
    out_ready = 1'b1;
    next();
    next();
    out_ready = 1'b0;
    #4;
    checks++;
    if ({level, out_data, overflow} !== {3'd3, 12'h012, 1'b1}) begin
      errors++;
      $display("FAIL flush_pre: got %h want %h",
               {level, out_data, overflow}, {3'd3, 12'h012, 1'b1});
    end
    next();
    flush = 1'b1; in_valid = 1'b1; in_data = 12'h7ff;
    #4;
    checks++;
    if ({ram_we, ram_re, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL flush_blocks: got %b want %b", {ram_we, ram_re, in_ready}, 3'b000);
    end
    next();
    idle();
    #4;
    checks++;
    if ({level, out_valid, overflow, almost_full} !== 6'b0) begin
      errors++;
      $display("FAIL flush_after: got %b want %b",
               {level, out_valid, overflow, almost_full}, 6'b0);
    end
    next();
  endtask

  // Continuous streaming: one sample per clock each way, addresses wrap 3->0.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 12);
      in_data  = DW'(12'h100 + i);
      #4;
      if (i < 12) begin
        checks++;
        if ({in_ready, ram_we, ram_waddr} !== {1'b1, 1'b1, AW'(i % 4)}) begin
          errors++;
          $display("FAIL stream_write%0d: got %b want %b", i,
                   {in_ready, ram_we, ram_waddr}, {1'b1, 1'b1, AW'(i % 4)});
        end
      end
      if (i >= 1 && i < 13) begin
        checks++;
        if ({ram_re, ram_raddr} !== {1'b1, AW'((i - 1) % 4)}) begin
          errors++;
          $display("FAIL stream_read%0d: got %b want %b", i,
                   {ram_re, ram_raddr}, {1'b1, AW'((i - 1) % 4)});
        end
      end
      if (i >= 2) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, DW'(12'h100 + i - 2)}) begin
          errors++;
          $display("FAIL stream_out%0d: got %h want %h", i,
                   {out_valid, out_data}, {1'b1, DW'(12'h100 + i - 2)});
        end
      end
      next();
    end
    idle();
    #4;
    checks++;
    if ({out_valid, level} !== 4'b0) begin
      errors++;
      $display("FAIL stream_end: got %b want %b", {out_valid, level}, 4'b0);
    end
  endtask

  // Full buffer: a pop does not open the input in the same cycle; then
  // a simultaneous pop+push keeps the level and order is preserved.
  task automatic test_full_pop_push();
    logic [DW-1:0] got[$];
    int budget;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = DW'(12'h200 + k); out_ready = 1'b0;
      next();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #4;
    checks++;
    if ({level, in_ready, ram_re} !== {3'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_pop: got %b want %b", {level, in_ready, ram_re}, {3'd5, 1'b0, 1'b1});
    end
    if (out_valid) got.push_back(out_data);
    next();
    in_valid = 1'b1; in_data = 12'h205;
    #4;
    checks++;
    if ({level, in_ready, ram_we, ram_re} !== {3'd4, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL full_pop_push: got %b want %b",
               {level, in_ready, ram_we, ram_re}, {3'd4, 1'b1, 1'b1, 1'b1});
    end
    if (out_valid) got.push_back(out_data);
    next();
    in_valid = 1'b0;
    #4;
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL full_level_hold: got %0d want 4", level);
    end
    budget = 0;
    while (level != 0 && budget < 20) begin
      if (out_valid) got.push_back(out_data);
      next();
      #4;
      budget++;
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL full_drain_count: got %0d want 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== DW'(12'h200 + i)) begin
        errors++;
        $display("FAIL full_order%0d: got %h want %h", i, got[i], DW'(12'h200 + i));
      end
    end
    idle();
    next();
  endtask

  // Randomized traffic against a queue model of the buffer contents.
  task automatic test_random();
    logic [DW-1:0] mq[$];
    logic [DW-1:0] hd;
    logic [DW-1:0] v;
    bit hv, ovf, e_rdy, e_wr, e_rd;
    int wcnt, rcnt, e_lvl, rdy_pct;
    mq.delete();
    hd = '0; v = '0; hv = 0; ovf = 0; wcnt = 0; rcnt = 0;
    idle();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rdy_pct   = (c < 200) ? 30 : 80;
      in_valid  = ($urandom_range(0, 99) < 65);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = DW'($urandom);
      #4;
      e_rdy = (mq.size() != DEPTH) && !flush;
      e_wr  = in_valid && e_rdy;
      e_rd  = (!hv || out_ready) && (mq.size() != 0) && !flush;
      e_lvl = mq.size() + int'(hv);
      checks++;
      if ({in_ready, ram_we, ram_re, out_valid, overflow, almost_full, level} !==
          {e_rdy, e_wr, e_rd, hv, ovf, (e_lvl >= int'(AF)), LW'(e_lvl)}) begin
        errors++;
        $display("FAIL rnd_ctrl c%0d: got %b want %b", c,
                 {in_ready, ram_we, ram_re, out_valid, overflow, almost_full, level},
                 {e_rdy, e_wr, e_rd, hv, ovf, (e_lvl >= int'(AF)), LW'(e_lvl)});
      end
      if (e_wr) begin
        checks++;
        if ({ram_waddr, ram_wdata} !== {AW'(wcnt % DEPTH), in_data}) begin
          errors++;
          $display("FAIL rnd_write c%0d: got %h want %h", c,
                   {ram_waddr, ram_wdata}, {AW'(wcnt % DEPTH), in_data});
        end
      end
      if (e_rd) begin
        checks++;
        if (ram_raddr !== AW'(rcnt % DEPTH)) begin
          errors++;
          $display("FAIL rnd_raddr c%0d: got %0d want %0d", c, ram_raddr, rcnt % DEPTH);
        end
      end
      if (hv) begin
        checks++;
        if (out_data !== hd) begin
          errors++;
          $display("FAIL rnd_head c%0d: got %h want %h", c, out_data, hd);
        end
      end
      if (flush) begin
        mq.delete(); hv = 0; ovf = 0; wcnt = 0; rcnt = 0;
      end else begin
        if (in_valid && !e_rdy) ovf = 1;
        if (e_rd) begin v = mq.pop_front(); rcnt++; end
        if (e_wr) begin mq.push_back(in_data); wcnt++; end
        if (!hv || out_ready) begin
          hv = e_rd;
          if (e_rd) hd = v;
        end
      end
      next();
    end
    idle();
  endtask

  // Reset dropped mid-stream, then the first push after release reads from address 0.
  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(12'h300 + i);
      next();
    end
    rst_n = 1'b0;
    #4;
    checks++;
    if ({in_ready, ram_we, ram_re} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_force: got %b want %b", {in_ready, ram_we, ram_re}, 3'b000);
    end
    next();
    #4;
    checks++;
    if ({level, out_valid, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_state: got %b want %b", {level, out_valid, overflow}, 5'b0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    next();
    in_valid = 1'b1; in_data = 12'h3aa;
    #4;
    checks++;
    if ({ram_we, ram_waddr} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_waddr: got %b want %b", {ram_we, ram_waddr}, {1'b1, 2'd0});
    end
    next();
    in_valid = 1'b0;
    #4;
    checks++;
    if ({ram_re, ram_raddr} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_raddr: got %b want %b", {ram_re, ram_raddr}, {1'b1, 2'd0});
    end
    next();
    #4;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 12'h3aa}) begin
      errors++;
      $display("FAIL rst_mid_head: got %h want %h", {out_valid, out_data}, {1'b1, 12'h3aa});
    end
    next();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_flush();
    test_back_to_back();
    test_full_pop_push();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
